rf_wb_queue: RTL

Writeback queue that drives the single write port of the bypassing register file (`writeregsel`/`writedata`/`write`). It accepts results from two producers, the memory/load path and the ALU path, through valid/ready handshakes. Accepted results are buffered in program order in a small FIFO and retired one per cycle into the register file. A per-register pending vector lets decode stall on registers whose value is still queued.

---
 rtl/rf_wb_queue_pkg.sv | 14 +
 rtl/rf_wbq_fifo.sv | 63 ++++++
 rtl/rf_wb_queue.sv | 91 +++++++++
 3 files changed

// File: rtl/rf_wb_queue_pkg.sv
// Shared definitions for the register-file writeback queue: register-select
// width, register count and the default writeback entry layout.
package rf_wb_queue_pkg;

  localparam int REG_SEL_W = 3;
  localparam int NUM_REGS  = 8;
  localparam int WB_DATA_W = 16;

  typedef struct packed {
    logic [REG_SEL_W-1:0] regsel;
    logic [WB_DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/rf_wbq_fifo.sv
// Circular buffer with up to two writes and one read per cycle. Exposes every
// slot plus an occupancy vector so the parent can scan queued destinations.
module rf_wbq_fifo
  import rf_wb_queue_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = wb_entry_t
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [1:0]                 i_push_count,
  input  entry_t                     i_push0,
  input  entry_t                     i_push1,
  input  logic                       i_pop,
  output entry_t                     o_head,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic [DEPTH-1:0]           o_occ,
  output logic [$clog2(DEPTH)-1:0]   o_rd_ptr,
  output entry_t                     o_entries [DEPTH]
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  entry_t          r_mem [DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic [PW-1:0]   w_wr_ptr1;

  assign w_wr_ptr1 = r_wr_ptr + PW'(1);

  // Payload storage needs no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (i_push_count != 2'd0) r_mem[r_wr_ptr]  <= i_push0;
    if (i_push_count == 2'd2) r_mem[w_wr_ptr1] <= i_push1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + PW'(i_push_count);
      r_rd_ptr <= r_rd_ptr + PW'(i_pop);
      r_count  <= r_count + CW'(i_push_count) - CW'(i_pop);
    end
  end

  // Slot i is occupied when its distance past the read pointer is below count.
  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    logic [PW-1:0] w_off;
    assign w_off        = PW'(i) - r_rd_ptr;
    assign o_occ[i]     = ({1'b0, w_off} < r_count);
    assign o_entries[i] = r_mem[i];
  end

  assign o_head   = r_mem[r_rd_ptr];
  assign o_count  = r_count;
  assign o_rd_ptr = r_rd_ptr;

endmodule

// File: rtl/rf_wb_queue.sv
// Writeback queue merging load and ALU results in program order onto the
// single register-file write port, with a pending vector for decode stalls.
module rf_wb_queue
  import rf_wb_queue_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mem_valid,
  input  logic [REG_SEL_W-1:0]  mem_regsel,
  input  logic [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_ready,
  input  logic                  alu_valid,
  input  logic [REG_SEL_W-1:0]  alu_regsel,
  input  logic [DATA_WIDTH-1:0] alu_data,
  output logic                  alu_ready,
  output logic [REG_SEL_W-1:0]  writeregsel,
  output logic [DATA_WIDTH-1:0] writedata,
  output logic                  write,
  output logic [NUM_REGS-1:0]   pending,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [REG_SEL_W-1:0]  regsel;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  entry_t        w_head;
  entry_t        w_push0;
  entry_t        w_push1;
  entry_t        w_entries [DEPTH];
  logic [DEPTH-1:0] w_occ;
  logic [PW-1:0] w_rd_ptr;
  logic [CW:0]   w_free;
  logic          w_nonempty;
  logic          w_mem_acc;
  logic          w_alu_acc;
  logic [1:0]    w_push_count;

  assign w_nonempty = (count != '0);

  // The head always pops this cycle, so its slot is credited back up front.
  assign w_free    = (CW+1)'(DEPTH) - {1'b0, count} + {{CW{1'b0}}, w_nonempty};
  assign mem_ready = rst_n && (w_free >= (CW+1)'(1));
  assign alu_ready = rst_n && (w_free >= (CW+1)'(2));

  assign w_mem_acc    = mem_valid && mem_ready;
  assign w_alu_acc    = alu_valid && alu_ready;
  assign w_push_count = {1'b0, w_mem_acc} + {1'b0, w_alu_acc};

  // Load result is the older instruction, so it lands ahead of the ALU result.
  assign w_push0 = w_mem_acc ? entry_t'{regsel: mem_regsel, data: mem_data}
                             : entry_t'{regsel: alu_regsel, data: alu_data};
  assign w_push1 = entry_t'{regsel: alu_regsel, data: alu_data};

  rf_wbq_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_push_count (w_push_count),
    .i_push0      (w_push0),
    .i_push1      (w_push1),
    .i_pop        (w_nonempty),
    .o_head       (w_head),
    .o_count      (count),
    .o_occ        (w_occ),
    .o_rd_ptr     (w_rd_ptr),
    .o_entries    (w_entries)
  );

  // Head is excluded: the register-file bypass already exposes it this cycle.
  always_comb begin
    pending = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_occ[i] && (PW'(i) != w_rd_ptr)) pending[w_entries[i].regsel] = 1'b1;
    end
  end

  assign write       = w_nonempty;
  assign writeregsel = w_nonempty ? w_head.regsel : '0;
  assign writedata   = w_nonempty ? w_head.data   : '0;

endmodule
